cpu5_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch port and its load/store port.
- Replaces the separate pseudo instruction and data caches with one arbitrated array.
- Sits between cpu5_core and the memory model.
- Sequences each access: arbitrate, issue, wait the fixed memory latency, return data. At most one access is outstanding at a time.

---
 rtl/cpu5_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_cpu5_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu5_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch and load/store ports.
// Optional CPU5_ARB_RR_EN selects round-robin arbitration instead of D-priority with starve guard.
module cpu5_mem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AW         = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 1 = data port owns the access
  logic [2:0]      lat_q, lat_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;

  logic done, arb, any_req, pick_d;

  assign done    = (state_q == StWait) && (lat_q == 3'd1);
  assign arb     = (state_q == StIdle) || done;
  assign any_req = i_req | d_req;

`ifdef CPU5_ARB_RR_EN
  // On a tie the port that did not own the last access wins.
  assign pick_d = d_req && (!i_req || !owner_q);
`else
  logic [3:0] starve_q, starve_d;

  always_comb begin
    pick_d   = d_req && !(i_req && (starve_q == 4'(STARVE_MAX)));
    starve_d = starve_q;
    if (arb) begin
      if (!i_req || !pick_d) begin
        starve_d = '0;
      end else if (starve_q < 4'(STARVE_MAX)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      StIssue: begin
        lat_d   = 3'(MEM_LAT);
        state_d = StWait;
      end
      StWait:  lat_d = lat_q - 3'd1;
      default: ;
    endcase
    if (arb) begin
      if (any_req) begin
        state_d  = StIssue;
        owner_d  = pick_d;
        m_addr_d = pick_d ? d_addr : i_addr;
        m_we_d   = pick_d & d_we;
        if (pick_d) begin
          m_wdata_d = d_wdata;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      lat_q     <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_q     <= lat_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_en     = (state_q == StIssue);
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign i_gnt    = m_en && !owner_q;
  assign d_gnt    = m_en && owner_q;
  assign i_rvalid = done && !owner_q;
  assign d_rvalid = done && owner_q;
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  // Store acknowledges return zero data.
  assign d_rdata  = (d_rvalid && !m_we_q) ? m_rdata : '0;

endmodule

// File: tb/tb_cpu5_mem_arbiter.sv
// Directed self-checking bench for cpu5_mem_arbiter: instance a at MEM_LAT=1, instance b at 3.
module tb_cpu5_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_i_req, a_i_gnt, a_i_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
  logic [7:0]  a_i_addr, a_d_addr, a_m_addr;
  logic [31:0] a_i_rdata, a_d_wdata, a_d_rdata, a_m_wdata, a_m_rdata;
  logic        b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid, b_m_en, b_m_we;
  logic [7:0]  b_i_addr, b_d_addr, b_m_addr;
  logic [31:0] b_i_rdata, b_d_wdata, b_d_rdata, b_m_wdata, b_m_rdata;

  cpu5_mem_arbiter #(.XLEN(32), .AW(8), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .reset(reset),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid),
    .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_gnt(a_d_gnt),
    .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
  );

  cpu5_mem_arbiter #(.XLEN(32), .AW(8), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid),
    .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
  );

  // Memory a: one-cycle read, preloaded while reset is low.
  logic [31:0] mem_a [256];
  always @(posedge clk) begin
    if (!reset) begin
      mem_a[5]  <= 32'hDEADBEEF;
      mem_a[16] <= 32'h0;
      a_m_rdata <= 32'h0;
    end else if (a_m_en) begin
      if (a_m_we) mem_a[a_m_addr] <= a_m_wdata;
      a_m_rdata <= mem_a[a_m_addr];
    end
  end

  // Memory b: read-only pattern 0xB00000aa, three-cycle pipeline left running through reset.
  logic [31:0] b_p0 = 32'h0, b_p1 = 32'h0, b_p2 = 32'h0;
  always @(posedge clk) begin
    if (b_m_en) b_p0 <= {24'hB00000, b_m_addr};
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_m_rdata = b_p2;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g;

  initial begin
    {a_i_req, a_d_req, a_d_we, b_i_req, b_d_req, b_d_we} = '0;
    {a_i_addr, a_d_addr, b_i_addr, b_d_addr} = '0;
    {a_d_wdata, b_d_wdata} = '0;

    #2;
    check("rst_m_en",    32'(a_m_en), 0);
    check("rst_i_gnt",   32'(a_i_gnt), 0);
    check("rst_d_gnt",   32'(a_d_gnt), 0);
    check("rst_i_rvld",  32'(a_i_rvalid), 0);
    check("rst_d_rvld",  32'(a_d_rvalid), 0);
    check("rst_m_we",    32'(a_m_we), 0);
    check("rst_m_addr",  32'(a_m_addr), 0);
    check("rst_m_wdata", a_m_wdata, 0);
    check("rst_i_rdata", a_i_rdata, 0);
    check("rst_d_rdata", a_d_rdata, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single fetch
    a_i_addr = 8'h05;
    a_i_req  = 1'b1;
    tick();
    check("f_i_gnt",  32'(a_i_gnt), 1);
    check("f_m_en",   32'(a_m_en), 1);
    check("f_m_addr", 32'(a_m_addr), 32'h05);
    check("f_m_we",   32'(a_m_we), 0);
    check("f_d_gnt",  32'(a_d_gnt), 0);
    a_i_req = 1'b0;
    tick();
    check("f_i_rvld",  32'(a_i_rvalid), 1);
    check("f_i_rdata", a_i_rdata, 32'hDEADBEEF);
    check("f_d_rvld",  32'(a_d_rvalid), 0);
    check("f_m_en_lo", 32'(a_m_en), 0);
    tick();
    check("f_i_rvld_lo",  32'(a_i_rvalid), 0);
    check("f_i_rdata_lo", a_i_rdata, 0);
    check("f_m_addr_hold", 32'(a_m_addr), 32'h05);

    // Store then load
    a_d_we    = 1'b1;
    a_d_addr  = 8'h10;
    a_d_wdata = 32'h12345678;
    a_d_req   = 1'b1;
    tick();
    check("st_d_gnt",   32'(a_d_gnt), 1);
    check("st_m_we",    32'(a_m_we), 1);
    check("st_m_addr",  32'(a_m_addr), 32'h10);
    check("st_m_wdata", a_m_wdata, 32'h12345678);
    check("st_i_gnt",   32'(a_i_gnt), 0);
    a_d_req = 1'b0;
    tick();
    check("st_d_rvld",  32'(a_d_rvalid), 1);
    check("st_d_rdata", a_d_rdata, 0);
    tick();
    check("st_m_we_hold", 32'(a_m_we), 1);
    a_d_we  = 1'b0;
    a_d_req = 1'b1;
    tick();
    check("ld_d_gnt", 32'(a_d_gnt), 1);
    check("ld_m_we",  32'(a_m_we), 0);
    a_d_req = 1'b0;
    tick();
    check("ld_d_rvld",  32'(a_d_rvalid), 1);
    check("ld_d_rdata", a_d_rdata, 32'h12345678);
    tick();

    // Contention: both ports requesting continuously
    a_i_addr = 8'h05;
    a_d_addr = 8'h10;
    a_i_req  = 1'b1;
    a_d_req  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int t;
      t = 0;
      tick();
      while (!(a_i_gnt || a_d_gnt) && t < 8) begin
        tick();
        t++;
      end
`ifdef CPU5_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
      check($sformatf("grant%0d", k), 32'({a_i_gnt, a_d_gnt}), 32'(exp_g));
    end
    a_i_req = 1'b0;
    a_d_req = 1'b0;
    repeat (4) tick();

    // MEM_LAT=3 back-to-back loads on instance b
    b_d_addr = 8'h03;
    b_d_req  = 1'b1;
    begin
      int t;
      t = 0;
      tick();
      while (!b_m_en && t < 8) begin
        tick();
        t++;
      end
    end
    for (int c = 0; c < 12; c++) begin
      check($sformatf("lat_m_en%0d", c), 32'(b_m_en), 32'(c % 4 == 0));
      check($sformatf("lat_rvld%0d", c), 32'(b_d_rvalid), 32'(c % 4 == 3));
      if (c % 4 == 3) check($sformatf("lat_rdata%0d", c), b_d_rdata, 32'hB0000003);
      tick();
    end
    b_d_req = 1'b0;
    repeat (6) tick();

    // Asynchronous reset in the middle of a load's wait
    b_d_addr = 8'h07;
    b_d_req  = 1'b1;
    tick();
    check("ar_d_gnt", 32'(b_d_gnt), 1);
    b_d_req = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("ar_b_m_addr", 32'(b_m_addr), 0);
    check("ar_b_m_en",   32'(b_m_en), 0);
    check("ar_b_d_rvld", 32'(b_d_rvalid), 0);
    check("ar_b_d_rdata", b_d_rdata, 0);
    check("ar_a_m_addr", 32'(a_m_addr), 0);
    check("ar_a_m_we",   32'(a_m_we), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("ar_no_rvld%0d", c), 32'(b_d_rvalid), 0);
      check($sformatf("ar_no_rdata%0d", c), b_d_rdata, 0);
    end
    b_i_addr = 8'h09;
    b_i_req  = 1'b1;
    tick();
    check("ar_idle_gnt", 32'(b_i_gnt), 1);
    b_i_req = 1'b0;
    repeat (3) tick();
    check("ar_i_rvld",  32'(b_i_rvalid), 1);
    check("ar_i_rdata", b_i_rdata, 32'hB0000009);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
